// File: rtl/canny_sobel_grad_if.sv
// Window-to-gradient stream bundle between the line-buffer/matrix stage,
// the Sobel gradient stage and the non-maximum-suppression stage.
//
// Stream semantics: there is no ready/backpressure. A pixel is transferred
// on every rising clk edge where frame_clken is high inside frame_href.
// Between strobes the producer holds the window steady. The consumer must
// accept every strobe. frame_vsync marks the frame boundary.
interface canny_sobel_grad_if #(
    parameter int DATA_WIDTH = 8
) ();
    localparam int MW = DATA_WIDTH + 3;

    // Window side. p1x is the top row, px1 is the left column.
    logic                  matrix_frame_vsync;
    logic                  matrix_frame_href;
    logic                  matrix_frame_clken;
    logic [DATA_WIDTH-1:0] matrix_p11, matrix_p12, matrix_p13;
    logic [DATA_WIDTH-1:0] matrix_p21, matrix_p22, matrix_p23;
    logic [DATA_WIDTH-1:0] matrix_p31, matrix_p32, matrix_p33;

    // Gradient side, aligned with the delayed frame timing.
    logic                  post_frame_vsync;
    logic                  post_frame_href;
    logic                  post_frame_clken;
    logic [MW-1:0]         post_grad_mag;
    logic [1:0]            post_grad_dir;
    logic                  post_edge_flag;

    // Upstream / stimulus side: drives the window and reads the results.
    modport master (
        output matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
        output matrix_p11, matrix_p12, matrix_p13,
        output matrix_p21, matrix_p22, matrix_p23,
        output matrix_p31, matrix_p32, matrix_p33,
        input  post_frame_vsync, post_frame_href, post_frame_clken,
        input  post_grad_mag, post_grad_dir, post_edge_flag
    );

    // Gradient stage side: consumes the window and produces the results.
    modport slave (
        input  matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
        input  matrix_p11, matrix_p12, matrix_p13,
        input  matrix_p21, matrix_p22, matrix_p23,
        input  matrix_p31, matrix_p32, matrix_p33,
        output post_frame_vsync, post_frame_href, post_frame_clken,
        output post_grad_mag, post_grad_dir, post_edge_flag
    );
endinterface

// File: rtl/canny_sobel_grad.sv
// Sobel gradient stage of the Canny pipeline: L1 magnitude, 4-bin
// direction and threshold flag, three free-running pipeline stages with the
// frame timing delayed by the same three cycles. Border pixels (first two
// columns of each line, first two lines of each frame) are forced to zero.
module canny_sobel_grad #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH+2:0] grad_thresh,
    canny_sobel_grad_if.slave     bus
);
    localparam int MW = DATA_WIDTH + 3;   // magnitude / signed gradient width
    localparam int SW = DATA_WIDTH + 2;   // one-sided partial sum width
    localparam int PW = MW + 3;           // direction comparison product width
    localparam logic [PW-1:0] K2 = PW'(2);
    localparam logic [PW-1:0] K5 = PW'(5);

    // ---------------- border counters ----------------
    logic [1:0] col_cnt, row_cnt;
    logic       href_d;
    logic       pix_valid;

    assign pix_valid = (col_cnt == 2'd2) && (row_cnt == 2'd2);

    // Column/row position counters, saturating at 2; vsync clear wins over
    // the href-falling-edge increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= 2'd0;
            row_cnt <= 2'd0;
            href_d  <= 1'b0;
        end else begin
            href_d <= bus.matrix_frame_href;
            if (!bus.matrix_frame_href)
                col_cnt <= 2'd0;
            else if (bus.matrix_frame_clken && col_cnt != 2'd2)
                col_cnt <= col_cnt + 2'd1;
            if (bus.matrix_frame_vsync)
                row_cnt <= 2'd0;
            else if (href_d && !bus.matrix_frame_href && row_cnt != 2'd2)
                row_cnt <= row_cnt + 2'd1;
        end
    end

    // ---------------- frame timing delay ----------------
    logic [2:0] vsync_sr, href_sr, clken_sr;

    // Pure 3-cycle delay of the sync signals.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_sr <= 3'd0;
            href_sr  <= 3'd0;
            clken_sr <= 3'd0;
        end else begin
            vsync_sr <= {vsync_sr[1:0], bus.matrix_frame_vsync};
            href_sr  <= {href_sr[1:0],  bus.matrix_frame_href};
            clken_sr <= {clken_sr[1:0], bus.matrix_frame_clken};
        end
    end

    // ---------------- S1: partial sums ----------------
    logic [SW-1:0] s1_pos_x, s1_neg_x, s1_pos_y, s1_neg_y;
    logic          s1_valid;

    // Right/left columns for Gx, top/bottom rows for Gy, centre tap doubled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_pos_x <= '0;
            s1_neg_x <= '0;
            s1_pos_y <= '0;
            s1_neg_y <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_pos_x <= {2'b00, bus.matrix_p13} + {1'b0, bus.matrix_p23, 1'b0} + {2'b00, bus.matrix_p33};
            s1_neg_x <= {2'b00, bus.matrix_p11} + {1'b0, bus.matrix_p21, 1'b0} + {2'b00, bus.matrix_p31};
            s1_pos_y <= {2'b00, bus.matrix_p11} + {1'b0, bus.matrix_p12, 1'b0} + {2'b00, bus.matrix_p13};
            s1_neg_y <= {2'b00, bus.matrix_p31} + {1'b0, bus.matrix_p32, 1'b0} + {2'b00, bus.matrix_p33};
            s1_valid <= pix_valid;
        end
    end

    // ---------------- S2: signed gradients and absolute values ----------------
    logic signed [MW-1:0] gx, gy, gx_neg, gy_neg;
    logic [MW-2:0]        ax_c, ay_c;
    logic [MW-2:0]        s2_ax, s2_ay;
    logic                 s2_sx, s2_sy, s2_valid;

    // Gx/Gy cannot overflow MW signed bits; |G| fits MW-1 bits.
    always_comb begin
        gx     = $signed({1'b0, s1_pos_x}) - $signed({1'b0, s1_neg_x});
        gy     = $signed({1'b0, s1_pos_y}) - $signed({1'b0, s1_neg_y});
        gx_neg = -gx;
        gy_neg = -gy;
        ax_c   = gx[MW-1] ? gx_neg[MW-2:0] : gx[MW-2:0];
        ay_c   = gy[MW-1] ? gy_neg[MW-2:0] : gy[MW-2:0];
    end

    // Register magnitudes and signs (zero counts as positive).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_ax    <= '0;
            s2_ay    <= '0;
            s2_sx    <= 1'b0;
            s2_sy    <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s2_ax    <= ax_c;
            s2_ay    <= ay_c;
            s2_sx    <= gx[MW-1];
            s2_sy    <= gy[MW-1];
            s2_valid <= s1_valid;
        end
    end

    // ---------------- S3: magnitude, direction, flag ----------------
    logic [MW-1:0] mag_c;
    logic [PW-1:0] ax_ext, ay_ext;
    logic [1:0]    dir_c;
    logic          gate_c, flag_c;
    logic [MW-1:0] mag_q;
    logic [1:0]    dir_q;
    logic          flag_q;

    // Direction bins use tan(22.5)~2/5 and tan(67.5)~5/2; href_sr[1] is the
    // href that will leave alongside this result.
    always_comb begin
        mag_c  = {1'b0, s2_ax} + {1'b0, s2_ay};
        ax_ext = PW'(s2_ax);
        ay_ext = PW'(s2_ay);
        dir_c  = 2'd0;
        if (ay_ext * K5 <= ax_ext * K2)
            dir_c = 2'd0;
        else if (ay_ext * K2 >= ax_ext * K5)
            dir_c = 2'd2;
        else if (s2_sx == s2_sy)
            dir_c = 2'd1;
        else
            dir_c = 2'd3;
        gate_c = href_sr[1] && s2_valid;
        flag_c = gate_c && (mag_c != '0) && (mag_c >= grad_thresh);
    end

    // Output registers, zeroed outside valid active pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q  <= '0;
            dir_q  <= 2'd0;
            flag_q <= 1'b0;
        end else begin
            mag_q  <= gate_c ? mag_c : '0;
            dir_q  <= gate_c ? dir_c : 2'd0;
            flag_q <= flag_c;
        end
    end

    assign bus.post_frame_vsync = vsync_sr[2];
    assign bus.post_frame_href  = href_sr[2];
    assign bus.post_frame_clken = clken_sr[2];
    assign bus.post_grad_mag    = mag_q;
    assign bus.post_grad_dir    = dir_q;
    assign bus.post_edge_flag   = flag_q;
endmodule

// File: doc/canny_sobel_grad.md
# canny_sobel_grad

Sobel gradient stage of the Canny edge pipeline. Consumes the 3x3 window and frame timing produced by the upstream line-buffer/matrix stage and computes, per pixel, the L1 gradient magnitude, a 4-bin quantised gradient direction and a threshold flag. Frame timing is delayed to stay aligned with the results. Output feeds the non-maximum-suppression stage.

## Interface
- DATA_WIDTH, 8, pixel width; magnitude width MW = DATA_WIDTH+3
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- matrix_frame_vsync  in  1  frame sync from window stage, active-high
- matrix_frame_href  in  1  line valid from window stage
- matrix_frame_clken  in  1  pixel strobe from window stage
- matrix_p11..matrix_p33  in  DATA_WIDTH each  window; p1x top row, p3x bottom row, px1 left column, px3 right column
- grad_thresh  in  MW  edge threshold, sampled every cycle
- post_frame_vsync  out  1  vsync delayed 3 cycles
- post_frame_href  out  1  href delayed 3 cycles
- post_frame_clken  out  1  clken delayed 3 cycles
- post_grad_mag  out  MW  |Gx|+|Gy|, unsigned
- post_grad_dir  out  2  0 = 0°, 1 = 45°, 2 = 90°, 3 = 135°
- post_edge_flag  out  1  post_grad_mag >= grad_thresh

## Operation
- Gx = (p13 + 2·p23 + p33) − (p11 + 2·p21 + p31); Gy = (p11 + 2·p12 + p13) − (p31 + 2·p32 + p33); signed MW bits, range ±4·(2^DATA_WIDTH−1), no overflow.
- ax = |Gx|, ay = |Gy|, each MW−1 bits unsigned. Magnitude ax+ay fits MW bits exactly, no saturation.
- Direction: ay·5 <= ax·2 → 0; else ay·2 >= ax·5 → 2; else sign(Gx) == sign(Gy) → 1, otherwise 3. Gx = Gy = 0 → 0. Sign of 0 is positive. Comparisons use MW+3-bit unsigned products.
- Border counters at input side:
  - col_cnt, 2-bit saturating at 2: increments on matrix_frame_clken while matrix_frame_href = 1; cleared when href = 0.
  - row_cnt, 2-bit saturating at 2: increments on href falling edge; cleared while matrix_frame_vsync = 1.
  - Pixel is valid when col_cnt >= 2 and row_cnt >= 2, evaluated before that cycle's increment. The valid bit travels with the data pipeline.
- Output gating: if delayed href = 0 or valid = 0, then post_grad_mag = 0, post_grad_dir = 0 and post_edge_flag = 0. The flag is additionally forced to 0 when mag = 0, so grad_thresh = 0 never flags a zero gradient.
- Pipeline, free-running every cycle with no stalls; upstream holds the window when clken is low.
  - S1: positive and negative partial sums, valid bit.
  - S2: Gx, Gy, ax, ay, signs.
  - S3: mag, dir, flag registered to outputs.
- Sync signals pass through 3-stage shift registers: no logic, only the delay.

## Timing
- Latency 3 cycles from window/sync inputs to all outputs. A window presented at cycle n appears at cycle n+3 together with its sync signals.
- Throughput 1 pixel/cycle. Back-to-back clken is supported.
- Reset: all outputs, pipeline registers, shift registers and counters are 0 immediately on rst_n falling, asynchronously.
- Reset mid-frame: outputs stay 0 until 3 cycles after the first clocked cycle after release. Counters restart at 0, so the next 2 rows of a resumed frame are masked.
- grad_thresh is compared in S3 using the value present in that cycle. It is not captured per frame.
- Simultaneous href fall and vsync high: row_cnt clear takes priority over increment.

## Test plan
- Vertical edge, left column 0 and right column 100, row_cnt/col_cnt past border, grad_thresh = 300 -> 3 cycles later mag = 400, dir = 0, flag = 1.
- Horizontal edge, top row 100 and bottom row 0 -> mag = 400, dir = 2. Same window with grad_thresh = 401 -> flag = 0.
- Diagonals: p12 = p13 = p23 = 100, rest 0 -> Gx = Gy = 300, mag = 600, dir = 1. The mirrored window p12 = p11 = p21 = 100 -> mag = 600, dir = 3. Extremes: p12 = p13 = p23 = 255, rest 0 -> mag = 1530; flat window of 255 -> mag = 0, dir = 0, flag = 0.
- Border masking: new frame (vsync pulse), 3 lines of 8 strobes with vertical-edge data -> rows 0–1 entirely 0; row 2 strobes 0–1 give 0 and strobes 2–7 give 400. post_frame_* equals the inputs delayed exactly 3 cycles throughout.
- clken gaps: strobes on alternate cycles within href -> the output clken pattern matches with a 3-cycle delay, and results are identical to the back-to-back case.
- Assert rst_n low mid-line -> all outputs 0 the same cycle. After release, the first valid (non-masked) result only appears after 2 further href falling edges.
